// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the single-clock FIFO:
//   level_width()   - bits needed to hold an occupancy of 0..2**addr_width
//   level_t         - occupancy type for the default configuration
//   thresholds_ok() - range check on the almost-full / almost-empty thresholds,
//                     used as an elaboration-time assertion by sync_fifo_flags
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    // Occupancy runs 0..DEPTH inclusive, so one more value than DEPTH.
    function automatic int level_width(input int addr_width);
        return $clog2((1 << addr_width) + 1);
    endfunction

    localparam int DEFAULT_ADDR_WIDTH  = 3;
    localparam int DEFAULT_LEVEL_WIDTH = level_width(DEFAULT_ADDR_WIDTH);

    typedef logic [DEFAULT_LEVEL_WIDTH-1:0] level_t;

    // almost_full threshold must be 1..DEPTH, almost_empty 0..DEPTH-1.
    function automatic bit thresholds_ok(input int addr_width,
                                         input int af_thresh,
                                         input int ae_thresh);
        int depth;
        depth = 1 << addr_width;
        return (addr_width >= 1) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// read port.
//   Standard build : read port is registered; rd_data loads on rd_en and
//                    otherwise holds. rd_data resets to 0.
//   SYNC_FIFO_FWFT_EN defined : read port is a combinational address read, so
//                    the word at rd_addr is always visible.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - async active-low reset for the read register (standard only)
//   rd_en    - load the read register (standard only)
//   wr_en    - write wr_data into wr_addr
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - read data
// Storage contents are never reset.
// -----------------------------------------------------------------------------
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                  rst_n,
    input  logic                  rd_en,
`endif
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds, synchronous flush and sticky
// overflow / underflow flags. Storage lives in fifo_mem; pointers, level and
// flags are kept here.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read).
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   clear        - synchronous flush, overrides wr_en / rd_en
//   wr_en        - write request
//   wr_data      - write data
//   rd_en        - read request (pop)
//   rd_data      - read data
//   rd_valid     - standard: pulse when rd_data holds a newly popped word
//                  FWFT: head word present (!empty)
//   full         - level == DEPTH
//   empty        - level == 0
//   almost_full  - level >= AF_THRESH
//   almost_empty - level <= AE_THRESH
//   level        - occupancy 0..DEPTH
//   overflow     - sticky, write attempted while full
//   underflow    - sticky, read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = level_width(ADDR_WIDTH);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    if (!thresholds_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH) || DATA_WIDTH < 1) begin : g_bad_params
        $error("sync_fifo_flags: DATA_WIDTH/ADDR_WIDTH/AF_THRESH/AE_THRESH out of range");
    end

    // Pointers carry one wrap bit above the storage address.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_next;
    logic                full_q;
    logic                empty_q;
    logic                af_q;
    logic                ae_q;
    logic                ovf_q;
    logic                unf_q;
    logic                acc_wr;
    logic                acc_rd;
    logic                mem_we;
    logic                mem_re;

    // Accept decisions use the registered flags only.
    assign acc_wr     = wr_en && !full_q;
    assign acc_rd     = rd_en && !empty_q;
    assign level_next = level_q + LW'(acc_wr) - LW'(acc_rd);

    // A flush suppresses the storage side effects of the same cycle.
    assign mem_we = acc_wr && !clear;
    assign mem_re = acc_rd && !clear;

    // Flags are registered from level_next so they line up with level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (acc_wr) begin
                wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            end
            if (acc_rd) begin
                rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
            end
            level_q <= level_next;
            full_q  <= (level_next == DEPTH_L);
            empty_q <= (level_next == '0);
            af_q    <= (level_next >= AF_L);
            ae_q    <= (level_next <= AE_L);
            if (wr_en && full_q) begin
                ovf_q <= 1'b1;
            end
            if (rd_en && empty_q) begin
                unf_q <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The head word is always on rd_data; it is valid whenever data is held.
    assign rd_valid = !empty_q;
`else
    logic rd_valid_q;

    // One-cycle pulse aligned with the registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= mem_re;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst_n   (rst_n),
        .rd_en   (mem_re),
`endif
        .wr_en   (mem_we),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
